// File: rtl/bpu_update_receiver_if.sv
// BPU update channel: commit side (master) to BTB update receiver (slave).
// Fire-and-forget: valid plus wr_req, no ready.
interface bpu_update_receiver_if #(
  parameter int XLEN = 64
);
  logic            bpuupd_valid;
  logic            bpuupd_wr_req;
  logic [XLEN-1:0] bpuupd_wr_pc;
  logic [XLEN-1:0] bpuupd_wr_predictedpc;
  logic [2:0]      bpuupd_wr_branchtype;
  logic            bpuupd_wr_predictbit;

  modport master (
    output bpuupd_valid,
    output bpuupd_wr_req,
    output bpuupd_wr_pc,
    output bpuupd_wr_predictedpc,
    output bpuupd_wr_branchtype,
    output bpuupd_wr_predictbit
  );

  modport slave (
    input bpuupd_valid,
    input bpuupd_wr_req,
    input bpuupd_wr_pc,
    input bpuupd_wr_predictedpc,
    input bpuupd_wr_branchtype,
    input bpuupd_wr_predictbit
  );
endinterface

// File: rtl/bpu_update_receiver.sv
// Update FIFO + 3-cycle RMW FSM into a flop BTB with 2-bit counters.
// Optional BPU_UPD_PERFCNT_EN adds update/alloc/drop counters.
module bpu_update_receiver #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 16,
  parameter int QDEPTH  = 4
) (
  input  logic            clk_i,
  input  logic            arst_i,
  bpu_update_receiver_if.slave upd,
  input  logic            flush_i,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_hit,
  output logic [XLEN-1:0] lookup_target,
  output logic [2:0]      lookup_type,
  output logic            lookup_taken,
  output logic            upd_busy,
  output logic            upd_drop
`ifdef BPU_UPD_PERFCNT_EN
  ,
  output logic [31:0]     perf_upd_cnt,
  output logic [31:0]     perf_alloc_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);
  localparam int IW = $clog2(ENTRIES);
  localparam int QW = $clog2(QDEPTH);
  localparam int TH = TAG_W + IW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic [2:0]      typ;
    logic            pbit;
  } upd_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  logic [ENTRIES-1:0] bv;
  logic [TAG_W-1:0]   btag [ENTRIES];
  logic [XLEN-1:0]    btgt [ENTRIES];
  logic [2:0]         btyp [ENTRIES];
  logic [1:0]         bctr [ENTRIES];

  upd_t        q [QDEPTH];
  logic [QW:0] wp, rp;
  upd_t        wk;
  state_t      state_q, state_d;

  logic [IW-1:0]    n_idx;
  logic [TAG_W-1:0] n_tag;
  logic [XLEN-1:0]  n_tgt;
  logic [2:0]       n_typ;
  logic [1:0]       n_ctr;
  logic             n_we, n_alloc;

  logic take, empty, full, pop, push, drop_d;
  logic commit;

  assign take  = upd.bpuupd_valid & upd.bpuupd_wr_req;
  assign empty = (wp == rp);
  assign full  = (wp[QW] != rp[QW]) &&
                 (wp[QW-1:0] == rp[QW-1:0]);
  assign pop   = (state_q == IDLE) & ~empty & ~flush_i;
  // a pop frees the slot this very cycle
  assign push   = take & ~flush_i & (~full | pop);
  assign drop_d = take & ~flush_i & full & ~pop;
  assign commit = (state_q == WR) & n_we & ~flush_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wp <= '0;
      rp <= '0;
    end else if (flush_i) begin
      rp <= wp;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q[wp[QW-1:0]] <= '{
        pc:   upd.bpuupd_wr_pc,
        tgt:  upd.bpuupd_wr_predictedpc,
        typ:  upd.bpuupd_wr_branchtype,
        pbit: upd.bpuupd_wr_predictbit
      };
    end
    if (pop) wk <= q[rp[QW-1:0]];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = RD;
      RD:      state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  logic [IW-1:0]    w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [1:0]       w_ctr, nx_ctr;

  assign w_idx = wk.pc[IW+1:2];
  assign w_tag = wk.pc[TH:IW+2];
  assign w_hit = bv[w_idx] && (btag[w_idx] == w_tag);
  assign w_ctr = bctr[w_idx];

  always_comb begin
    nx_ctr = 2'b10;
    unique case (1'b1)
      w_hit & wk.pbit:
        nx_ctr = (w_ctr == 2'b11) ? w_ctr : w_ctr + 2'd1;
      w_hit & ~wk.pbit:
        nx_ctr = (w_ctr == 2'b00) ? w_ctr : w_ctr - 2'd1;
      default: nx_ctr = 2'b10;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      n_we    <= 1'b0;
      n_alloc <= 1'b0;
    end else if (flush_i) begin
      n_we    <= 1'b0;
      n_alloc <= 1'b0;
    end else if (state_q == RD) begin
      n_we    <= w_hit | wk.pbit;
      n_alloc <= ~w_hit & wk.pbit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == RD) begin
      n_idx <= w_idx;
      n_tag <= w_tag;
      n_tgt <= wk.tgt;
      n_typ <= wk.typ;
      n_ctr <= nx_ctr;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)      bv <= '0;
    else if (flush_i) bv <= '0;
    else if (commit) bv[n_idx] <= 1'b1;
  end

  // payload is only visible behind bv, which reset clears
  always_ff @(posedge clk_i) begin
    if (commit && !arst_i) begin
      btag[n_idx] <= n_tag;
      btgt[n_idx] <= n_tgt;
      btyp[n_idx] <= n_typ;
      bctr[n_idx] <= n_ctr;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) upd_drop <= 1'b0;
    else        upd_drop <= drop_d;
  end

  assign upd_busy = ~empty | (state_q != IDLE);

  logic [IW-1:0]    l_idx;
  logic [TAG_W-1:0] l_tag;

  assign l_idx = lookup_pc[IW+1:2];
  assign l_tag = lookup_pc[TH:IW+2];

  always_comb begin
    lookup_hit    = bv[l_idx] && (btag[l_idx] == l_tag);
    lookup_target = '0;
    lookup_type   = '0;
    lookup_taken  = 1'b0;
    if (lookup_hit) begin
      lookup_target = btgt[l_idx];
      lookup_type   = btyp[l_idx];
      lookup_taken  = bctr[l_idx][1];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[XLEN-1:TH+1],
                         lookup_pc[1:0],
                         wk.pc[XLEN-1:TH+1],
                         wk.pc[1:0]};

`ifdef BPU_UPD_PERFCNT_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      perf_upd_cnt   <= '0;
      perf_alloc_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (take)
        perf_upd_cnt <= perf_upd_cnt + 32'd1;
      if (commit && n_alloc)
        perf_alloc_cnt <= perf_alloc_cnt + 32'd1;
      if (upd_drop)
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule
